// File: rtl/l2_resp_tracker.sv
// In-order response steering for one L2 bank port: remembers the granted master per request.
// Optional protocol-error flag built only when L2_RESP_TRACK_ERR_EN is defined.
module l2_resp_tracker #(
  parameter int N_MASTERS  = 8,
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  req_gnt_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  output logic                  stall_o,
  input  logic                  r_valid_i,
  input  logic [DATA_WIDTH-1:0] r_rdata_i,
  output logic [N_MASTERS-1:0]  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  err_o
);

  localparam int PW = $clog2(DEPTH);

  logic [ID_WIDTH-1:0]   mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [N_MASTERS-1:0]  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic                  full;
  logic                  empty;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic [ID_WIDTH-1:0]   pop_id;

  assign full     = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_req = req_valid_i & req_gnt_i;
  assign pop      = r_valid_i & ~empty;
  // At full, a same-cycle pop frees the slot the push lands in.
  assign push     = push_req & (~full | pop);
  assign pop_id   = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    vld_d  = '0;
    data_d = data_q;
    id_d   = id_q;
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
      data_d = r_rdata_i;
      id_d   = pop_id;
      for (int i = 0; i < N_MASTERS; i++) begin
        vld_d[i] = (pop_id == ID_WIDTH'(i));
      end
    end
    cnt_d = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      id_q   <= id_d;
    end
  end

  // ID storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= req_id_i;
    end
  end

  assign stall_o       = full;
  assign r_valid_o     = vld_q;
  assign r_rdata_o     = data_q;
  assign r_id_o        = id_q;
  assign outstanding_o = cnt_q;

`ifdef L2_RESP_TRACK_ERR_EN
  logic err_q, err_d;
  logic ovf;
  logic udf;
  logic bad_id;

  assign ovf    = push_req & full & ~pop;
  assign udf    = r_valid_i & empty;
  assign bad_id = pop & (int'(pop_id) >= N_MASTERS);
  assign err_d  = err_q | ovf | udf | bad_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_l2_resp_tracker.sv
// Directed bench for l2_resp_tracker: ordering, full/overflow, underflow, async reset.
module tb_l2_resp_tracker;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_gnt_i;
  logic [2:0]  req_id_i;
  logic        stall_o;
  logic        r_valid_i;
  logic [31:0] r_rdata_i;
  logic [7:0]  r_valid_o;
  logic [31:0] r_rdata_o;
  logic [2:0]  r_id_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int total;
  int bad;

`ifdef L2_RESP_TRACK_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  l2_resp_tracker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_gnt_i     (req_gnt_i),
    .req_id_i      (req_id_i),
    .stall_o       (stall_o),
    .r_valid_i     (r_valid_i),
    .r_rdata_i     (r_rdata_i),
    .r_valid_o     (r_valid_o),
    .r_rdata_o     (r_rdata_o),
    .r_id_o        (r_id_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id);
    req_valid_i = 1'b1;
    req_gnt_i   = 1'b1;
    req_id_i    = id;
    step();
    req_valid_i = 1'b0;
    req_gnt_i   = 1'b0;
  endtask

  logic [7:0] exp_v [4];

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_gnt_i   = 1'b0;
    req_id_i    = '0;
    r_valid_i   = 1'b0;
    r_rdata_i   = '0;
    step();
    step();
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_vld", 32'(r_valid_o), 0);
    chk("rst_data", r_rdata_o, 0);
    chk("rst_id", 32'(r_id_o), 0);
    chk("rst_out", 32'(outstanding_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst_n = 1'b1;
    step();

    // single read
    push(3'd5);
    chk("t1_out1", 32'(outstanding_o), 1);
    step();
    step();
    r_valid_i = 1'b1;
    r_rdata_i = 32'hCAFE0001;
    step();
    r_valid_i = 1'b0;
    chk("t1_vld", 32'(r_valid_o), 32'h20);
    chk("t1_id", 32'(r_id_o), 5);
    chk("t1_data", r_rdata_o, 32'hCAFE0001);
    chk("t1_out0", 32'(outstanding_o), 0);
    step();
    chk("t1_vld_off", 32'(r_valid_o), 0);
    chk("t1_data_hold", r_rdata_o, 32'hCAFE0001);

    // ordering
    push(3'd2);
    push(3'd7);
    push(3'd0);
    chk("t2_nostall", 32'(stall_o), 0);
    push(3'd3);
    chk("t2_stall", 32'(stall_o), 1);
    chk("t2_out4", 32'(outstanding_o), 4);
    exp_v[0] = 8'h04;
    exp_v[1] = 8'h80;
    exp_v[2] = 8'h01;
    exp_v[3] = 8'h08;
    r_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_rdata_i = 32'h100 + 32'(i);
      step();
      chk("t2_vld", 32'(r_valid_o), 32'(exp_v[i]));
      chk("t2_data", r_rdata_o, 32'h100 + 32'(i));
      if (i == 0) chk("t2_unstall", 32'(stall_o), 0);
    end
    r_valid_i = 1'b0;
    step();
    chk("t2_idle", 32'(r_valid_o), 0);
    chk("t2_out0", 32'(outstanding_o), 0);

    // full plus simultaneous push/pop
    push(3'd1);
    push(3'd2);
    push(3'd3);
    push(3'd4);
    chk("t3_full", 32'(stall_o), 1);
    req_valid_i = 1'b1;
    req_gnt_i   = 1'b1;
    req_id_i    = 3'd6;
    r_valid_i   = 1'b1;
    step();
    req_valid_i = 1'b0;
    req_gnt_i   = 1'b0;
    chk("t3_vld", 32'(r_valid_o), 32'h02);
    chk("t3_out", 32'(outstanding_o), 4);
    chk("t3_stall", 32'(stall_o), 1);
    exp_v[0] = 8'h04;
    exp_v[1] = 8'h08;
    exp_v[2] = 8'h10;
    exp_v[3] = 8'h40;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_drain", 32'(r_valid_o), 32'(exp_v[i]));
    end
    r_valid_i = 1'b0;
    step();
    chk("t3_out0", 32'(outstanding_o), 0);
    chk("t3_err", 32'(err_o), 0);

    // overflow
    for (int i = 0; i < 4; i++) push(3'd5);
    push(3'd1);
    chk("t4_out", 32'(outstanding_o), 4);
    chk("t4_err", 32'(err_o), 32'(ERR));
    r_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_drain", 32'(r_valid_o), 32'h20);
    end
    r_valid_i = 1'b0;
    step();
    chk("t4_out0", 32'(outstanding_o), 0);

    // async reset with work outstanding
    push(3'd1);
    push(3'd2);
    push(3'd3);
    chk("t5_out3", 32'(outstanding_o), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_stall", 32'(stall_o), 0);
    chk("t5_vld", 32'(r_valid_o), 0);
    chk("t5_data", r_rdata_o, 0);
    chk("t5_id", 32'(r_id_o), 0);
    chk("t5_out", 32'(outstanding_o), 0);
    chk("t5_err", 32'(err_o), 0);
    step();
    rst_n = 1'b1;
    step();

    // underflow after reset
    r_valid_i = 1'b1;
    r_rdata_i = 32'hDEAD0000;
    step();
    r_valid_i = 1'b0;
    chk("t6_vld", 32'(r_valid_o), 0);
    chk("t6_out", 32'(outstanding_o), 0);
    chk("t6_err", 32'(err_o), 32'(ERR));
    chk("t6_data", r_rdata_o, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
